// File: rtl/alu_pkg.sv
// Shared constants and decode types for the ALU issue stage:
// ALU function codes, MIPS opcode/funct values and the decode result struct.
package alu_pkg;

   localparam logic [5:0] FUN_ADD   = 6'b000000;
   localparam logic [5:0] FUN_SUB   = 6'b000001;
   localparam logic [5:0] FUN_AND   = 6'b011000;
   localparam logic [5:0] FUN_OR    = 6'b011110;
   localparam logic [5:0] FUN_XOR   = 6'b010110;
   localparam logic [5:0] FUN_NOR   = 6'b010001;
   localparam logic [5:0] FUN_PASSA = 6'b011010;
   localparam logic [5:0] FUN_SLL   = 6'b100000;
   localparam logic [5:0] FUN_SRL   = 6'b100001;
   localparam logic [5:0] FUN_SRA   = 6'b100011;
   localparam logic [5:0] FUN_EQ    = 6'b110011;
   localparam logic [5:0] FUN_NEQ   = 6'b110001;
   localparam logic [5:0] FUN_LT    = 6'b110101;
   localparam logic [5:0] FUN_LEZ   = 6'b111101;
   localparam logic [5:0] FUN_LTZ   = 6'b111011;
   localparam logic [5:0] FUN_GTZ   = 6'b111111;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL    = 6'h00;
   localparam logic [5:0] FN_SRL    = 6'h02;
   localparam logic [5:0] FN_SRA    = 6'h03;
   localparam logic [5:0] FN_SLLV   = 6'h04;
   localparam logic [5:0] FN_SRLV   = 6'h06;
   localparam logic [5:0] FN_SRAV   = 6'h07;
   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;
   localparam logic [5:0] FN_ADD    = 6'h20;
   localparam logic [5:0] FN_ADDU   = 6'h21;
   localparam logic [5:0] FN_SUB    = 6'h22;
   localparam logic [5:0] FN_SUBU   = 6'h23;
   localparam logic [5:0] FN_AND    = 6'h24;
   localparam logic [5:0] FN_OR     = 6'h25;
   localparam logic [5:0] FN_XOR    = 6'h26;
   localparam logic [5:0] FN_NOR    = 6'h27;
   localparam logic [5:0] FN_SLT    = 6'h2A;
   localparam logic [5:0] FN_SLTU   = 6'h2B;

   typedef enum logic [2:0] {A_RS, A_SHAMT, A_RS_SHAMT, A_LUI, A_ZERO} a_sel_e;
   typedef enum logic [1:0] {B_RT, B_IMM, B_ZERO} b_sel_e;
   typedef enum logic [1:0] {DEST_RD, DEST_RT, DEST_NONE} dest_sel_e;

   typedef struct packed {
      logic [5:0] fun;
      logic       sign;
      a_sel_e     a_sel;
      b_sel_e     b_sel;
      logic       ext_zero;
      logic       wen;
      dest_sel_e  dest_sel;
      logic       illegal;
   } decode_t;

   localparam decode_t DEC_ILLEGAL = '{fun: FUN_ADD, sign: 1'b0, a_sel: A_ZERO, b_sel: B_ZERO,
                                       ext_zero: 1'b0, wen: 1'b0, dest_sel: DEST_NONE,
                                       illegal: 1'b1};

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: maps opcode/funct to the ALU function,
// sign mode, operand sources and write-back control.
module alu_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output decode_t     dec
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_fields;

   assign op = instr[31:26];
   assign fn = instr[5:0];
   // rs and immediate bits only matter in the operand path, not here.
   assign unused_fields = ^{instr[25:21], instr[15:6]};

   always_comb begin
      // NOTE: every field gets a default first so no path leaves dec unassigned and infers a latch.
      dec = '{fun: FUN_ADD, sign: 1'b0, a_sel: A_RS, b_sel: B_RT, ext_zero: 1'b0,
              wen: 1'b1, dest_sel: DEST_RD, illegal: 1'b0};
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD:  begin dec.fun = FUN_ADD; dec.sign = 1'b1; end
               FN_ADDU: dec.fun = FUN_ADD;
               FN_SUB:  begin dec.fun = FUN_SUB; dec.sign = 1'b1; end
               FN_SUBU: dec.fun = FUN_SUB;
               FN_AND:  dec.fun = FUN_AND;
               FN_OR:   dec.fun = FUN_OR;
               FN_XOR:  dec.fun = FUN_XOR;
               FN_NOR:  dec.fun = FUN_NOR;
               FN_SLT:  begin dec.fun = FUN_LT; dec.sign = 1'b1; end
               FN_SLTU: dec.fun = FUN_LT;
               FN_SLL:  begin dec.fun = FUN_SLL; dec.a_sel = A_SHAMT; end
               FN_SRL:  begin dec.fun = FUN_SRL; dec.a_sel = A_SHAMT; end
               FN_SRA:  begin dec.fun = FUN_SRA; dec.a_sel = A_SHAMT; end
               FN_SLLV: begin dec.fun = FUN_SLL; dec.a_sel = A_RS_SHAMT; end
               FN_SRLV: begin dec.fun = FUN_SRL; dec.a_sel = A_RS_SHAMT; end
               FN_SRAV: begin dec.fun = FUN_SRA; dec.a_sel = A_RS_SHAMT; end
               FN_JR:   dec.wen = 1'b0;
               FN_JALR: dec.wen = 1'b1;
               default: dec = DEC_ILLEGAL;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: begin
            dec.b_sel    = B_IMM;
            dec.dest_sel = DEST_RT;
            case (op)
               OP_ADDI:  dec.sign = 1'b1;
               OP_SLTI:  begin dec.fun = FUN_LT; dec.sign = 1'b1; end
               OP_SLTIU: dec.fun = FUN_LT;
               OP_ANDI:  begin dec.fun = FUN_AND; dec.ext_zero = 1'b1; end
               OP_ORI:   begin dec.fun = FUN_OR; dec.ext_zero = 1'b1; end
               OP_LUI:   begin dec.fun = FUN_PASSA; dec.a_sel = A_LUI; end
               OP_LW:    dec.sign = 1'b1;
               OP_SW:    begin dec.sign = 1'b1; dec.wen = 1'b0; end
               default:  dec.fun = FUN_ADD;
            endcase
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
            dec.sign     = 1'b1;
            dec.wen      = 1'b0;
            dec.dest_sel = DEST_NONE;
            dec.b_sel    = B_ZERO;
            case (op)
               OP_BEQ:  begin dec.fun = FUN_EQ; dec.b_sel = B_RT; end
               OP_BNE:  begin dec.fun = FUN_NEQ; dec.b_sel = B_RT; end
               OP_BLEZ: dec.fun = FUN_LEZ;
               OP_BGTZ: dec.fun = FUN_GTZ;
               default: begin
                  // REGIMM with rt != 0 (bgez and friends) is not supported.
                  if (instr[20:16] == 5'd0) dec.fun = FUN_LTZ;
                  else                      dec = DEC_ILLEGAL;
               end
            endcase
         end
         default: dec = DEC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: one-deep registered pipeline slot driving the ALU
// operand/function interface, with valid/ready handshakes and flush.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [5:0]        ALUFun,
   output logic              Sign,
   output logic [4:0]        out_wreg,
   output logic              out_wen,
   output logic              out_illegal
);

   decode_t           dec;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] a_mux;
   logic [DATA_W-1:0] b_mux;
   logic [4:0]        dest;
   logic              accept;
   logic              out_valid_next;

   alu_decode u_decode (
      .instr (instr),
      .dec   (dec)
   );

   assign imm_ext = dec.ext_zero ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

   always_comb begin
      a_mux = '0;
      b_mux = '0;
      dest  = 5'd0;
      case (dec.a_sel)
         A_RS:       a_mux = rs_data;
         A_SHAMT:    a_mux = {27'd0, instr[10:6]};
         A_RS_SHAMT: a_mux = {27'd0, rs_data[4:0]};
         A_LUI:      a_mux = {instr[15:0], 16'h0000};
         default:    a_mux = '0;
      endcase
      case (dec.b_sel)
         B_RT:    b_mux = rt_data;
         B_IMM:   b_mux = imm_ext;
         default: b_mux = '0;
      endcase
      case (dec.dest_sel)
         DEST_RD: dest = instr[15:11];
         DEST_RT: dest = instr[20:16];
         default: dest = 5'd0;
      endcase
   end

   // Flush wins over a same-cycle offer: the input is dropped, not loaded.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      if (flush)          out_valid_next = 1'b0;
      else if (accept)    out_valid_next = 1'b1;
      else if (out_ready) out_valid_next = 1'b0;
      else                out_valid_next = out_valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         A           <= '0;
         B           <= '0;
         ALUFun      <= FUN_ADD;
         Sign        <= 1'b0;
         out_wreg    <= 5'd0;
         out_wen     <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         out_valid <= out_valid_next;
         if (accept) begin
            A           <= a_mux;
            B           <= b_mux;
            ALUFun      <= dec.fun;
            Sign        <= dec.sign;
            out_wreg    <= dest;
            out_wen     <= dec.wen && (dest != 5'd0);
            out_illegal <= dec.illegal;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed scoreboard bench for alu_issue: expected ALU-interface values are
// queued on issue and compared when the stage presents them.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [5:0]  ALUFun;
   logic        Sign;
   logic [4:0]  out_wreg;
   logic        out_wen;
   logic        out_illegal;

   int n_compared = 0;
   int n_mismatched = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  fun;
      logic        sign;
      logic [4:0]  wreg;
      logic        wen;
      logic        ill;
      bit          cmp_sign;
      bit          cmp_wreg;
   } exp_t;

   exp_t sb[$];

   alu_issue dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instr       (instr),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .A           (A),
      .B           (B),
      .ALUFun      (ALUFun),
      .Sign        (Sign),
      .out_wreg    (out_wreg),
      .out_wen     (out_wen),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic exp_t mk(input logic [31:0] a, b, input logic [5:0] fun, input logic sign,
                               input logic [4:0] wreg, input logic wen, ill,
                               input bit cs = 1'b1, input bit cw = 1'b1);
      exp_t e;
      e.a = a; e.b = b; e.fun = fun; e.sign = sign; e.wreg = wreg;
      e.wen = wen; e.ill = ill; e.cmp_sign = cs; e.cmp_wreg = cw;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_compared++;
      assert (obs === expv) else begin
         n_mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [31:0] ins, rs, rt, input exp_t e);
      in_valid  = 1'b1;
      instr     = ins;
      rs_data   = rs;
      rt_data   = rt;
      out_ready = 1'b1;
      flush     = 1'b0;
      sb.push_back(e);
   endtask

   task automatic expect_head(input string tag, input bit do_pop);
      exp_t e;
      check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".sb"}, {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
         e = sb[0];
         check({tag, ".A"}, A, e.a);
         check({tag, ".B"}, B, e.b);
         check({tag, ".ALUFun"}, {26'd0, ALUFun}, {26'd0, e.fun});
         if (e.cmp_sign) check({tag, ".Sign"}, {31'd0, Sign}, {31'd0, e.sign});
         if (e.cmp_wreg) check({tag, ".wreg"}, {27'd0, out_wreg}, {27'd0, e.wreg});
         check({tag, ".wen"}, {31'd0, out_wen}, {31'd0, e.wen});
         check({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
         if (do_pop) void'(sb.pop_front());
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".A"}, A, 32'd0);
      check({tag, ".B"}, B, 32'd0);
      check({tag, ".ALUFun"}, {26'd0, ALUFun}, 32'd0);
      check({tag, ".Sign"}, {31'd0, Sign}, 32'd0);
      check({tag, ".wreg"}, {27'd0, out_wreg}, 32'd0);
      check({tag, ".wen"}, {31'd0, out_wen}, 32'd0);
      check({tag, ".illegal"}, {31'd0, out_illegal}, 32'd0);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("reset");
      check("reset.in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b1;
      @(negedge clk);

      // Back-to-back stream with out_ready held high.
      send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'h1,
           mk(32'h7FFF_FFFF, 32'h1, 6'b000000, 1'b1, 5'd3, 1'b1, 1'b0));
      @(negedge clk); expect_head("add", 1'b1);
      send(rtype(5'd0, 5'd2, 5'd4, 5'd29, 6'h03), 32'h0000_DEAD, 32'h8000_0001,
           mk(32'h0000_001D, 32'h8000_0001, 6'b100011, 1'b0, 5'd4, 1'b1, 1'b0));
      @(negedge clk); expect_head("sra", 1'b1);
      send(rtype(5'd0, 5'd2, 5'd5, 5'd3, 6'h02), 32'h0, 32'h0000_00F0,
           mk(32'h3, 32'h0000_00F0, 6'b100001, 1'b0, 5'd5, 1'b1, 1'b0));
      @(negedge clk); expect_head("srl", 1'b1);
      send(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h07), 32'hFFFF_FFE5, 32'h8000_0000,
           mk(32'h5, 32'h8000_0000, 6'b100011, 1'b0, 5'd6, 1'b1, 1'b0));
      @(negedge clk); expect_head("srav", 1'b1);
      send(itype(6'h09, 5'd1, 5'd6, 16'hFFFF), 32'h10, 32'h0,
           mk(32'h10, 32'hFFFF_FFFF, 6'b000000, 1'b0, 5'd6, 1'b1, 1'b0));
      @(negedge clk); expect_head("addiu", 1'b1);
      send(itype(6'h0C, 5'd1, 5'd7, 16'hFFFF), 32'h1234_5678, 32'h0,
           mk(32'h1234_5678, 32'h0000_FFFF, 6'b011000, 1'b0, 5'd7, 1'b1, 1'b0));
      @(negedge clk); expect_head("andi", 1'b1);
      send(itype(6'h0F, 5'd0, 5'd8, 16'h1234), 32'h0000_AAAA, 32'h0,
           mk(32'h1234_0000, 32'h0000_1234, 6'b011010, 1'b0, 5'd8, 1'b1, 1'b0));
      @(negedge clk); expect_head("lui", 1'b1);
      send(itype(6'h06, 5'd0, 5'd0, 16'h0010), 32'h0, 32'h99,
           mk(32'h0, 32'h0, 6'b111101, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      @(negedge clk); expect_head("blez", 1'b1);
      send(itype(6'h05, 5'd0, 5'd9, 16'h0004), 32'h0, 32'h55,
           mk(32'h0, 32'h55, 6'b110001, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      @(negedge clk); expect_head("bne", 1'b1);
      send(itype(6'h2B, 5'd3, 5'd10, 16'hFFF8), 32'h1000, 32'h0,
           mk(32'h1000, 32'hFFFF_FFF8, 6'b000000, 1'b1, 5'd10, 1'b0, 1'b0));
      @(negedge clk); expect_head("sw", 1'b1);
      send(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'h5, 32'h6,
           mk(32'h5, 32'h6, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0));
      @(negedge clk); expect_head("addu_r0", 1'b1);
      send(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h1, 32'h2,
           mk(32'h0, 32'h0, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      @(negedge clk); expect_head("illegal", 1'b1);

      // Back-pressure: hold ori while a different instruction is offered.
      send(itype(6'h0D, 5'd1, 5'd11, 16'h8001), 32'h0F0F_0000, 32'h0,
           mk(32'h0F0F_0000, 32'h0000_8001, 6'b011110, 1'b0, 5'd11, 1'b1, 1'b0));
      @(negedge clk); expect_head("bp0", 1'b0);
      out_ready = 1'b0;
      instr = rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h26);
      rs_data = 32'h1111_1111; rt_data = 32'h2222_2222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_head($sformatf("stall%0d", i), 1'b0);
         check($sformatf("stall%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      end

      // Flush with an offered input: held item drains, offer is dropped.
      out_ready = 1'b1;
      flush = 1'b1;
      void'(sb.pop_front());
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush.valid", {31'd0, out_valid}, 32'd0);
      check("flush.A_kept", A, 32'h0F0F_0000);
      @(negedge clk);
      check("flush.valid2", {31'd0, out_valid}, 32'd0);
      check("flush.wreg_kept", {27'd0, out_wreg}, 32'd11);

      // Reset while an item is stalled.
      send(itype(6'h08, 5'd1, 5'd13, 16'hFFFF), 32'h1, 32'h0,
           mk(32'h1, 32'hFFFF_FFFF, 6'b000000, 1'b1, 5'd13, 1'b1, 1'b0));
      @(negedge clk); expect_head("addi", 1'b1);
      in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_reset("rst_stall");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst.valid", {31'd0, out_valid}, 32'd0);
      check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage in front of the MIPS ALU: takes an instruction plus register-file operands from ID, decodes the ALU function code, sign mode and operand sources, and presents them registered to the ALU in EX. It is the driving end of the ALU operand/function interface (A, B, ALUFun, Sign), behaves as a one-deep pipeline register with valid/ready handshakes on both sides, and supports stall back-pressure and flush.

## Interface
- DATA_W, 32, operand width; only 32 is supported.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ID holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- instr  in  32  instruction word
- rs_data  in  32  rs operand (already forwarded)
- rt_data  in  32  rt operand (already forwarded)
- flush  in  1  kill stage contents (branch/jump taken)
- out_valid  out  1  A/B/ALUFun/Sign/out_* valid toward EX
- out_ready  in  1  EX consumes this cycle
- A  out  32  ALU operand A
- B  out  32  ALU operand B
- ALUFun  out  6  ALU function code
- Sign  out  1  1 = signed overflow/compare semantics
- out_wreg  out  5  destination register
- out_wen  out  1  result is written back
- out_illegal  out  1  opcode/funct not decodable

## Operation
- ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
- Shifts: A = shift amount (zero-extended shamt, or rs_data[4:0] for the variable forms), B = rt_data.
- R-type (op 0), funct -> ALUFun/Sign: 20 ADD/1, 21 ADD/0, 22 SUB/1, 23 SUB/0, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A LT/1, 2B LT/0, 00 SLL, 02 SRL, 03 SRA, 04 SLL, 06 SRL, 07 SRA, 08/09 ADD with out_wen=0 (08) or 1 (09). Dest = rd. For the logic and shift functions Sign=0.
- I-type: 08 addi ADD/1, 09 addiu ADD/0, 0A slti LT/1, 0B sltiu LT/0, 0C andi AND (zero-ext), 0D ori OR (zero-ext), 0F lui PASSA with A={imm,16'h0}, 23 lw ADD/1, 2B sw ADD/1 out_wen=0. For these, A = rs_data, B = imm sign-extended unless zero-ext is noted. Dest = rt.
- Branches, all with out_wen=0 and Sign=1: 04 beq EQ (A=rs, B=rt), 05 bne NEQ, 06 blez LEZ (A=rs, B=0), 07 bgtz GTZ, 01 bltz LTZ.
- Undecodable: ALUFun=ADD, A=B=0, out_wen=0, out_illegal=1.
- out_wen is forced 0 whenever the destination register is 0.

## Timing
- All outputs are registered; latency is 1 cycle from acceptance.
- in_ready = !out_valid || out_ready (combinational). An input is accepted when in_valid && in_ready.
- Output register loads on acceptance. out_valid next = accepted ? 1 : (out_ready ? 0 : out_valid).
- While out_valid && !out_ready, every output holds stable.
- flush has top priority: the next cycle out_valid=0, and an input offered in the same cycle is discarded (not accepted into the register).
- Reset (async assert, sync release) gives: out_valid=0, A=B=0, ALUFun=000000, Sign=0, out_wreg=0, out_wen=0, out_illegal=0. Reset asserted mid-handshake drops the held item.
- Back-to-back: with out_ready=1 held, one instruction issues per cycle.

## Structure
- Package alu_pkg holds:
  - localparams for all ALUFun codes;
  - opcode and funct constants;
  - a decode result struct (fun, sign, a_sel, b_sel, ext_zero, wen, dest_sel, illegal).
- Sub-module alu_decode: purely combinational decode from instr to the decode struct.
- alu_issue contains the operand muxes, the handshake, and the output register.

## Test plan
- add: rs=7FFFFFFF, rt=1, funct 20 -> after 1 cycle ALUFun=000000, Sign=1, A=7FFFFFFF, B=1, out_wreg=rd.
- sra rd,rt,29 (rt=80000001) -> A=0000001D, B=80000001, ALUFun=100011. srl shamt 3 -> ALUFun=100001, A=3.
- addiu imm=FFFF -> B=FFFFFFFF, Sign=0. andi imm=FFFF -> B=0000FFFF, ALUFun=011000. lui imm=1234 -> A=12340000, ALUFun=011010.
- Branches with rs=0: blez -> ALUFun=111101, B=0, out_wen=0. bne -> 110001.
- Back-pressure: out_ready=0 for 3 cycles -> outputs frozen and in_ready=0. Then flush together with in_valid -> out_valid=0 next cycle and the new input is dropped.
- Illegal opcode 3F -> out_illegal=1, out_wen=0. Reset mid-stall -> all outputs at their reset values.
